// File: rtl/cofre_pkg.sv
// cofre_pkg: shared state encoding for the cofre safe-lock controller family.
// The 3-bit codes are what the display logic decodes. 100 and 101 are unused.
package cofre_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_OPEN    = 3'b000;
  localparam logic [STATE_W-1:0] ST_ARM_N   = 3'b001;
  localparam logic [STATE_W-1:0] ST_ARM_R   = 3'b010;
  localparam logic [STATE_W-1:0] ST_ENTRY   = 3'b011;
  localparam logic [STATE_W-1:0] ST_BLOCKED = 3'b110;
  localparam logic [STATE_W-1:0] ST_EMERG   = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_OPEN    = ST_OPEN,
    S_ARM_N   = ST_ARM_N,
    S_ARM_R   = ST_ARM_R,
    S_ENTRY   = ST_ENTRY,
    S_BLOCKED = ST_BLOCKED,
    S_EMERG   = ST_EMERG
  } cofre_state_t;

  // The door pin is released only while open or in emergency.
  function automatic logic is_unlocked(input cofre_state_t s);
    return (s == S_OPEN) || (s == S_EMERG);
  endfunction

endpackage

// File: rtl/cofre_btn_sync.sv
// cofre_btn_sync: 2-flop synchroniser for an asynchronous level input plus a
// one-cycle pulse on each synchronised 1->0 transition.
// RESET_VAL is the idle level, so reset never produces a spurious pulse.
module cofre_btn_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic hist_r;

  // Two metastability stages, then one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= RESET_VAL;
      sync2_r <= RESET_VAL;
      hist_r  <= RESET_VAL;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  assign level = sync2_r;
  assign fall  = hist_r & ~sync2_r;

endmodule

// File: rtl/cofre_ctrl_param.sv
// cofre_ctrl_param: parametrised safe-lock controller.
// Handles multi-digit password entry and programming, an attempt budget, and a
// timed lockout that releases automatically.
// Optional feature: define COFRE_AUTO_RELOCK_EN to relock the door after
// RELOCK_CYCLES idle cycles in OPEN. It is disabled by default.
module cofre_ctrl_param
  import cofre_pkg::*;
#(
  parameter int DIGIT_W       = 4,
  parameter int N_DIGITS      = 4,
  parameter int MAX_TRIES     = 3,
  parameter int LOCK_CYCLES   = 1024,
  parameter int RELOCK_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           mode_normal,
  input  logic                           enter_n,
  input  logic [DIGIT_W-1:0]             digit,
  input  logic                           saf,
  input  logic                           emerg,
  input  logic                           set_pw,
  output logic [STATE_W-1:0]             state,
  output logic [STATE_W-1:0]             prev_state,
  output logic                           door_locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [DIGIT_W*N_DIGITS-1:0]    stored_pw
);

  localparam int PW_W        = DIGIT_W * N_DIGITS;
  localparam int TW          = $clog2(MAX_TRIES + 1);
  localparam int DW          = $clog2(N_DIGITS + 1);
  localparam int LOCK_LAST   = (LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0;
  localparam int LCW         = (LOCK_LAST > 0) ? $clog2(LOCK_LAST + 1) : 1;
  localparam bit LOCK_AUTO   = (LOCK_CYCLES > 0);
  localparam int RELOCK_LAST = (RELOCK_CYCLES > 0) ? RELOCK_CYCLES - 1 : 0;

  // Registers
  cofre_state_t    state_r;
  cofre_state_t    prev_state_r;
  logic [TW-1:0]   tries_r;
  logic [DW-1:0]   dcnt_r;
  logic [PW_W-1:0] pbuf_r;
  logic [PW_W-1:0] ebuf_r;
  logic [PW_W-1:0] stored_pw_r;
  logic [LCW-1:0]  lock_cnt_r;
  logic            mode_prev_r;

  // Next-state values
  cofre_state_t    state_nxt_s;
  cofre_state_t    prev_nxt_s;
  logic [TW-1:0]   tries_nxt_s;
  logic [DW-1:0]   dcnt_nxt_s;
  logic [PW_W-1:0] pbuf_nxt_s;
  logic [PW_W-1:0] ebuf_nxt_s;
  logic [PW_W-1:0] pw_nxt_s;
  logic [LCW-1:0]  lock_nxt_s;

  // Synchronised inputs and derived events
  logic            press_s;
  logic            mode_s;
  logic            mode_rise_s;
  logic            mode_fall_s;
  logic            enter_lvl_unused_s;
  logic            mode_fall_unused_s;
  logic            relock_s;

  // Shared datapath terms
  logic [DW-1:0]   dcnt_inc_s;
  logic            digits_done_s;
  logic [PW_W-1:0] pbuf_shift_s;
  logic [PW_W-1:0] ebuf_shift_s;

  cofre_btn_sync #(.RESET_VAL(1'b1)) u_enter_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (enter_n),
    .level    (enter_lvl_unused_s),
    .fall     (press_s)
  );

  cofre_btn_sync #(.RESET_VAL(1'b0)) u_mode_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (mode_normal),
    .level    (mode_s),
    .fall     (mode_fall_unused_s)
  );

  // A mode change is an edge of the synchronised level. The reset-time 0->1
  // settling in ARM_N therefore is not a change to remote mode.
  assign mode_rise_s = mode_s & ~mode_prev_r;
  assign mode_fall_s = ~mode_s & mode_prev_r;

  // Digits shift in MSB first. The cast keeps the low PW_W bits.
  assign dcnt_inc_s    = dcnt_r + DW'(1);
  assign digits_done_s = (dcnt_inc_s == DW'(N_DIGITS));
  assign pbuf_shift_s  = PW_W'({pbuf_r, digit});
  assign ebuf_shift_s  = PW_W'({ebuf_r, digit});

`ifdef COFRE_AUTO_RELOCK_EN
  localparam int IW = (RELOCK_LAST > 0) ? $clog2(RELOCK_LAST + 1) : 1;
  logic [IW-1:0] idle_cnt_r;

  assign relock_s = (state_r == S_OPEN) && (idle_cnt_r == IW'(RELOCK_LAST));

  // Idle timer: counts OPEN cycles without a press; any press, relock or exit restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= '0;
    end else if ((state_r != S_OPEN) || press_s || relock_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + IW'(1);
    end
  end
`else
  logic relock_cfg_unused_s;
  assign relock_s            = 1'b0;
  assign relock_cfg_unused_s = (RELOCK_LAST == 0);
`endif

  // Next-state and datapath decode for every state
  always_comb begin
    state_nxt_s = state_r;
    prev_nxt_s  = prev_state_r;
    tries_nxt_s = tries_r;
    dcnt_nxt_s  = dcnt_r;
    pbuf_nxt_s  = pbuf_r;
    ebuf_nxt_s  = ebuf_r;
    pw_nxt_s    = stored_pw_r;
    lock_nxt_s  = '0;
    case (state_r)
      S_OPEN: begin
        if (press_s && set_pw) begin
          if (digits_done_s) begin
            pw_nxt_s   = pbuf_shift_s;
            pbuf_nxt_s = '0;
            dcnt_nxt_s = '0;
          end else begin
            pbuf_nxt_s = pbuf_shift_s;
            dcnt_nxt_s = dcnt_inc_s;
          end
        end else if (press_s || relock_s) begin
          // Leaving OPEN drops any half-programmed code
          pbuf_nxt_s  = '0;
          dcnt_nxt_s  = '0;
          state_nxt_s = mode_s ? S_ARM_N : S_ARM_R;
        end else begin
          state_nxt_s = S_OPEN;
        end
      end
      S_ARM_N: begin
        if (mode_fall_s) begin
          state_nxt_s = S_ARM_R;
          prev_nxt_s  = S_ARM_N;
        end else if (press_s) begin
          // This press only arms entry; its digit is not consumed
          state_nxt_s = S_ENTRY;
          prev_nxt_s  = S_ARM_N;
          ebuf_nxt_s  = '0;
          dcnt_nxt_s  = '0;
        end else begin
          state_nxt_s = S_ARM_N;
        end
      end
      S_ARM_R: begin
        if (mode_rise_s) begin
          state_nxt_s = S_ARM_N;
          prev_nxt_s  = S_ARM_R;
        end else if (press_s && saf) begin
          state_nxt_s = S_OPEN;
          prev_nxt_s  = S_ARM_R;
          dcnt_nxt_s  = '0;
          pbuf_nxt_s  = '0;
        end else begin
          state_nxt_s = S_ARM_R;
        end
      end
      S_ENTRY: begin
        if (press_s) begin
          if (!digits_done_s) begin
            ebuf_nxt_s = ebuf_shift_s;
            dcnt_nxt_s = dcnt_inc_s;
          end else if (ebuf_shift_s == stored_pw_r) begin
            state_nxt_s = S_OPEN;
            tries_nxt_s = TW'(MAX_TRIES);
            ebuf_nxt_s  = '0;
            dcnt_nxt_s  = '0;
            pbuf_nxt_s  = '0;
          end else if (tries_r > TW'(1)) begin
            tries_nxt_s = tries_r - TW'(1);
            ebuf_nxt_s  = '0;
            dcnt_nxt_s  = '0;
          end else begin
            tries_nxt_s = '0;
            state_nxt_s = S_BLOCKED;
            ebuf_nxt_s  = '0;
            dcnt_nxt_s  = '0;
          end
        end else begin
          state_nxt_s = S_ENTRY;
        end
      end
      S_BLOCKED: begin
        if (emerg) begin
          state_nxt_s = S_EMERG;
        end else if (LOCK_AUTO && (lock_cnt_r == LCW'(LOCK_LAST))) begin
          state_nxt_s = S_ENTRY;
          tries_nxt_s = TW'(MAX_TRIES);
          ebuf_nxt_s  = '0;
          dcnt_nxt_s  = '0;
        end else if (LOCK_AUTO) begin
          lock_nxt_s = lock_cnt_r + LCW'(1);
        end else begin
          lock_nxt_s = lock_cnt_r;
        end
      end
      S_EMERG: begin
        state_nxt_s = S_EMERG;
      end
      default: begin
        state_nxt_s = S_OPEN;
        dcnt_nxt_s  = '0;
        pbuf_nxt_s  = '0;
        ebuf_nxt_s  = '0;
      end
    endcase
  end

  // State, attempt budget, buffers, counters and stored code registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_ARM_N;
      prev_state_r <= S_ARM_N;
      tries_r      <= TW'(MAX_TRIES);
      dcnt_r       <= '0;
      pbuf_r       <= '0;
      ebuf_r       <= '0;
      stored_pw_r  <= '0;
      lock_cnt_r   <= '0;
      mode_prev_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_state_r <= prev_nxt_s;
      tries_r      <= tries_nxt_s;
      dcnt_r       <= dcnt_nxt_s;
      pbuf_r       <= pbuf_nxt_s;
      ebuf_r       <= ebuf_nxt_s;
      stored_pw_r  <= pw_nxt_s;
      lock_cnt_r   <= lock_nxt_s;
      mode_prev_r  <= mode_s;
    end
  end

  assign state       = state_r;
  assign prev_state  = prev_state_r;
  assign tries_left  = tries_r;
  assign stored_pw   = stored_pw_r;
  assign door_locked = ~is_unlocked(state_r);

endmodule

// File: tb/tb_cofre_ctrl_param.sv
// Directed bench for cofre_ctrl_param with DIGIT_W=4, N_DIGITS=4, MAX_TRIES=3,
// LOCK_CYCLES=16 and RELOCK_CYCLES=8.
// The COFRE_AUTO_RELOCK_EN macro selects the matching relock expectation.
module tb_cofre_ctrl_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode_normal;
  logic        enter_n;
  logic [3:0]  digit;
  logic        saf;
  logic        emerg;
  logic        set_pw;
  logic [2:0]  state;
  logic [2:0]  prev_state;
  logic        door_locked;
  logic [1:0]  tries_left;
  logic [15:0] stored_pw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cofre_ctrl_param #(
    .DIGIT_W(4), .N_DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .RELOCK_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode_normal (mode_normal),
    .enter_n     (enter_n),
    .digit       (digit),
    .saf         (saf),
    .emerg       (emerg),
    .set_pw      (set_pw),
    .state       (state),
    .prev_state  (prev_state),
    .door_locked (door_locked),
    .tries_left  (tries_left),
    .stored_pw   (stored_pw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One button press: low for 3 edges (press lands on the 3rd), then high for 3
  task automatic press_key(input logic [3:0] d, input logic sp, input logic sf);
    digit   = d;
    set_pw  = sp;
    saf     = sf;
    enter_n = 1'b0;
    repeat (3) @(negedge clk);
    enter_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) begin
      press_key(c[i*4 +: 4], 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; enter_n = 1'b1; mode_normal = 1'b1;
    digit = 4'd0; saf = 1'b0; emerg = 1'b0; set_pw = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_prev", 32'(prev_state), 32'd1);
    chk("rst_pw", 32'(stored_pw), 32'h0);
    chk("rst_tries", 32'(tries_left), 32'd3);
    chk("rst_locked", 32'(door_locked), 32'd1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", 32'(state), 32'd1);

    // Open with the default all-zero code
    press_key(4'd0, 1'b0, 1'b0);
    chk("arm_to_entry", 32'(state), 32'd3);
    enter_code(16'h0000);
    chk("zero_code_open", 32'(state), 32'd0);
    chk("open_unlocked", 32'(door_locked), 32'd0);
    chk("open_prev", 32'(prev_state), 32'd1);

    // Program 1,2,3,4
    press_key(4'd1, 1'b1, 1'b0);
    press_key(4'd2, 1'b1, 1'b0);
    press_key(4'd3, 1'b1, 1'b0);
    chk("prog_partial_pw", 32'(stored_pw), 32'h0);
    press_key(4'd4, 1'b1, 1'b0);
    chk("prog_pw", 32'(stored_pw), 32'h1234);
    chk("prog_stay_open", 32'(state), 32'd0);

    // Correct code
    press_key(4'd0, 1'b0, 1'b0);
    chk("open_to_armn", 32'(state), 32'd1);
    press_key(4'd0, 1'b0, 1'b0);
    chk("armn_to_entry", 32'(state), 32'd3);
    enter_code(16'h1234);
    chk("good_code_state", 32'(state), 32'd0);
    chk("good_code_tries", 32'(tries_left), 32'd3);

    // Reset after two digits of an entry
    press_key(4'd0, 1'b0, 1'b0);
    press_key(4'd0, 1'b0, 1'b0);
    press_key(4'd1, 1'b0, 1'b0);
    press_key(4'd2, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd1);
    chk("midrst_pw", 32'(stored_pw), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_press_on_release", 32'(state), 32'd1);
    chk("midrst_tries", 32'(tries_left), 32'd3);

    // Three wrong codes against stored 0000
    press_key(4'd0, 1'b0, 1'b0);
    chk("entry_again", 32'(state), 32'd3);
    enter_code(16'h1235);
    chk("wrong1_tries", 32'(tries_left), 32'd2);
    chk("wrong1_state", 32'(state), 32'd3);
    enter_code(16'h0001);
    chk("wrong2_tries", 32'(tries_left), 32'd1);
    enter_code(16'h4321);
    chk("wrong3_state", 32'(state), 32'd6);
    chk("wrong3_tries", 32'(tries_left), 32'd0);
    chk("blocked_locked", 32'(door_locked), 32'd1);

    // Auto-release: 16 cycles in BLOCKED, 3 already spent inside press_key
    repeat (12) @(negedge clk);
    chk("blocked_hold", 32'(state), 32'd6);
    @(negedge clk);
    chk("release_state", 32'(state), 32'd3);
    chk("release_tries", 32'(tries_left), 32'd3);

    // Second lockout, emergency on the expiry cycle
    enter_code(16'h9999);
    enter_code(16'h9999);
    enter_code(16'h9999);
    chk("blocked_again", 32'(state), 32'd6);
    repeat (12) @(negedge clk);
    emerg = 1'b1;
    @(negedge clk);
    chk("emerg_wins", 32'(state), 32'd7);
    chk("emerg_unlocked", 32'(door_locked), 32'd0);
    emerg = 1'b0;
    repeat (3) @(negedge clk);
    chk("emerg_terminal", 32'(state), 32'd7);

    // Remote mode
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_from_emerg", 32'(state), 32'd1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    mode_normal = 1'b0;
    repeat (4) @(negedge clk);
    chk("mode_to_armr", 32'(state), 32'd2);
    press_key(4'd0, 1'b0, 1'b0);
    chk("armr_no_saf", 32'(state), 32'd2);
    press_key(4'd0, 1'b0, 1'b1);
    chk("armr_saf_open", 32'(state), 32'd0);
    chk("armr_prev", 32'(prev_state), 32'd2);
    mode_normal = 1'b1;

`ifdef COFRE_AUTO_RELOCK_EN
    repeat (4) @(negedge clk);
    chk("relock_not_yet", 32'(state), 32'd0);
    @(negedge clk);
    chk("relock_armn", 32'(state), 32'd1);
`else
    repeat (100) @(negedge clk);
    chk("no_relock", 32'(state), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
